// File: rtl/paddle_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// paddle_input_ctrl_if
// Command handshake between the paddle input controller and the Nios
// custom-instruction path of the Pong display top.
//   cmd_data  [31:0]  {22'b0, player, y[8:0]}  (player 0 = bar 1, 1 = bar 2)
//   cmd_valid         command available, held until accepted
//   cmd_ready         consumer accepts the command
// master: the command producer (paddle_input_ctrl); slave: the consumer.
// -----------------------------------------------------------------------------
interface paddle_input_ctrl_if;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/paddle_input_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_input_ctrl
// Turns the four raw, active-low player buttons into debounced, rate-limited,
// range-clamped paddle positions and emits bar-update commands through a
// valid/ready handshake, arbitrating round-robin between the two players.
//
// Ports:
//   CLK                 board clock, the only clock
//   i_rst               synchronous active-high reset
//   enable              game running; paddles move only while high
//   btn_up1/btn_dn1     player 1 raw keys (async, 0 = pressed)
//   btn_up2/btn_dn2     player 2 raw keys (async, 0 = pressed)
//   cmd                 command handshake (master side)
//   y_bar1/y_bar2       current clamped paddle positions
// -----------------------------------------------------------------------------
module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_DIV        = 250000,
    parameter int STEP            = 4,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 400,
    parameter int Y_INIT          = 200
) (
    input  logic                       CLK,
    input  logic                       i_rst,
    input  logic                       enable,
    input  logic                       btn_up1,
    input  logic                       btn_dn1,
    input  logic                       btn_up2,
    input  logic                       btn_dn2,
    paddle_input_ctrl_if.master        cmd,
    output logic [8:0]                 y_bar1,
    output logic [8:0]                 y_bar2
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TK_W = $clog2(STEP_DIV + 1);

    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0]   TK_LAST = TK_W'(STEP_DIV - 1);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
    localparam logic [8:0]        Y_INIT_9 = 9'(Y_INIT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Clamp a signed candidate position into [Y_MIN, Y_MAX]. The extra
    // headroom bits keep y-STEP from wrapping when y is near zero.
    function automatic logic [8:0] sat_y(input logic signed [10:0] v);
        logic [8:0] r;
        if (v < Y_MIN_S)
            r = Y_MIN_S[8:0];
        else if (v > Y_MAX_S)
            r = Y_MAX_S[8:0];
        else
            r = v[8:0];
        return r;
    endfunction

    // Button order in every 4-bit vector: {dn2, up2, dn1, up1}
    logic [3:0]      raw_n;
    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      pressed;
    logic [3:0]      stable;
    logic [DB_W-1:0] db_cnt [4];

    logic [TK_W-1:0] tick_cnt;
    logic            tick;
    logic            enable_d;
    logic            game_start;
    logic            move_en;

    logic [1:0]      mv_up;
    logic [1:0]      mv_dn;
    logic [8:0]      y_r  [2];
    logic [8:0]      y_mv [2];
    logic [1:0]      set_pend;
    logic [1:0]      clr_pend;
    logic [1:0]      pend;

    state_t          state;
    logic            last;
    logic            cur;
    logic            pick;
    logic            cmd_valid_r;
    logic [31:0]     cmd_data_r;

    assign raw_n = {btn_dn2, btn_up2, btn_dn1, btn_up1};

    // ---- stage: two-flop synchronizer (reset to released) ----
    always_ff @(posedge CLK) begin
        if (i_rst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= raw_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = ~sync_p1;

    // ---- stage: debounce, one disagreement counter per button ----
    always_ff @(posedge CLK) begin
        if (i_rst) begin
            stable <= '0;
            for (int i = 0; i < 4; i++)
                db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pressed[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= ~stable[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // ---- stage: movement tick and game-start edge ----
    always_ff @(posedge CLK) begin
        if (i_rst) begin
            tick_cnt <= '0;
            enable_d <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TK_W'(1);
            enable_d <= enable;
        end
    end

    assign tick       = (tick_cnt == TK_LAST);
    assign game_start = enable && !enable_d;
    assign move_en    = tick && enable && enable_d;

    assign mv_up = {stable[2], stable[0]};
    assign mv_dn = {stable[3], stable[1]};

    always_comb begin
        set_pend = '0;
        for (int p = 0; p < 2; p++) begin
            y_mv[p] = y_r[p];
            if (mv_up[p] && !mv_dn[p])
                y_mv[p] = sat_y($signed({2'b00, y_r[p]}) - STEP_S);
            else if (mv_dn[p] && !mv_up[p])
                y_mv[p] = sat_y($signed({2'b00, y_r[p]}) + STEP_S);
            set_pend[p] = game_start || (move_en && (y_mv[p] != y_r[p]));
        end
    end

    // ---- stage: paddle position registers ----
    always_ff @(posedge CLK) begin
        if (i_rst || game_start) begin
            for (int p = 0; p < 2; p++)
                y_r[p] <= Y_INIT_9;
        end else if (move_en) begin
            for (int p = 0; p < 2; p++)
                y_r[p] <= y_mv[p];
        end
    end

    // A pending bit is only retired when the position just sent is still the
    // current one; a move that happened after the command was latched keeps
    // the bit set so the newer position goes out next.
    always_comb begin
        clr_pend = '0;
        if ((state == S_SEND) && cmd.cmd_ready && (y_r[cur] == cmd_data_r[8:0]))
            clr_pend[cur] = 1'b1;
    end

    // When both players wait, serve the one not served last.
    assign pick = (pend == 2'b11) ? ~last : pend[1];

    // ---- stage: command FSM and pending bookkeeping ----
    always_ff @(posedge CLK) begin
        if (i_rst) begin
            state       <= S_IDLE;
            pend        <= '0;
            last        <= 1'b1;
            cur         <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_data_r  <= '0;
        end else begin
            pend <= (pend & ~clr_pend) | set_pend;
            case (state)
                S_IDLE: begin
                    if (pend != 2'b00) begin
                        cur         <= pick;
                        cmd_data_r  <= {22'b0, pick, y_r[pick]};
                        cmd_valid_r <= 1'b1;
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cmd.cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        last        <= cur;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd.cmd_valid = cmd_valid_r;
    assign cmd.cmd_data  = cmd_data_r;
    assign y_bar1        = y_r[0];
    assign y_bar2        = y_r[1];

endmodule
